// File: rtl/face_det_pkg.sv
// Shared definitions for the face-detection datapath: frame defaults, coordinate
// widths and the window selector's state encoding.
package face_det_pkg;

   localparam int IMG_W_DEF = 160;
   localparam int IMG_H_DEF = 120;
   localparam int COORD_W   = 8;
   localparam int SCALE_W   = 2;

   typedef enum logic [1:0] {
      SEL_IDLE = 2'b00,
      SEL_ADV  = 2'b01,
      SEL_CHK  = 2'b11,
      SEL_DONE = 2'b10
   } sel_state_e;

endpackage

// File: rtl/face_window_selector.sv
// Sliding-window scan generator: each start request yields the next candidate
// window (x fastest, then y, then scale) and flags when the frame is exhausted.
module face_window_selector
   import face_det_pkg::*;
#(
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter int WIN_MIN    = 24,
   parameter int WIN_INC    = 8,
   parameter int NUM_SCALES = 3,
   parameter int STEP       = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               select_window_start,
   input  logic               break_scan,
   output logic               done,
   output logic               windows_out,
   output logic [COORD_W-1:0] win_x,
   output logic [COORD_W-1:0] win_y,
   output logic [COORD_W-1:0] win_size,
   output logic [SCALE_W-1:0] win_scale
);

   sel_state_e state, state_nxt;

   logic               first;
   logic [COORD_W-1:0] prev_x, prev_y, prev_size;
   logic [SCALE_W-1:0] prev_scale;

   logic [COORD_W:0]   x_reach, y_next, y_reach;
   logic               x_wrap, y_wrap, exhausted;
   logic [SCALE_W:0]   scale_next;

   function automatic logic [COORD_W-1:0] size_of(input logic [SCALE_W:0] k);
      return COORD_W'(WIN_MIN + int'(k) * WIN_INC);
   endfunction

   // Bounds are checked one bit wider than the coordinates so x+size never wraps.
   always_comb begin
      x_reach    = {1'b0, win_x} + {1'b0, win_size};
      x_wrap     = x_reach > (COORD_W+1)'(IMG_W);
      y_next     = x_wrap ? ({1'b0, win_y} + (COORD_W+1)'(STEP)) : {1'b0, win_y};
      y_reach    = y_next + {1'b0, win_size};
      y_wrap     = y_reach > (COORD_W+1)'(IMG_H);
      scale_next = y_wrap ? ({1'b0, win_scale} + (SCALE_W+1)'(1)) : {1'b0, win_scale};
      exhausted  = scale_next == (SCALE_W+1)'(NUM_SCALES);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SEL_IDLE: if (select_window_start) state_nxt = SEL_ADV;
         SEL_ADV:  state_nxt = SEL_CHK;
         SEL_CHK:  state_nxt = SEL_DONE;
         SEL_DONE: state_nxt = SEL_IDLE;
         default:  state_nxt = SEL_IDLE;
      endcase
      if (break_scan) state_nxt = SEL_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SEL_IDLE;
      else        state <= state_nxt;
   end

   // The window in effect when a request starts is kept so an exhausted scan
   // can fall back to the last valid window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done        <= 1'b0;
         windows_out <= 1'b0;
         first       <= 1'b1;
         win_x       <= '0;
         win_y       <= '0;
         win_size    <= COORD_W'(WIN_MIN);
         win_scale   <= '0;
         prev_x      <= '0;
         prev_y      <= '0;
         prev_size   <= COORD_W'(WIN_MIN);
         prev_scale  <= '0;
      end else if (break_scan) begin
         done        <= 1'b0;
         windows_out <= 1'b0;
         first       <= 1'b1;
         win_x       <= '0;
         win_y       <= '0;
         win_size    <= COORD_W'(WIN_MIN);
         win_scale   <= '0;
         prev_x      <= '0;
         prev_y      <= '0;
         prev_size   <= COORD_W'(WIN_MIN);
         prev_scale  <= '0;
      end else begin
         done <= (state_nxt == SEL_DONE);
         case (state)
            SEL_ADV: begin
               if (!windows_out) begin
                  prev_x     <= win_x;
                  prev_y     <= win_y;
                  prev_size  <= win_size;
                  prev_scale <= win_scale;
                  if (first) begin
                     first     <= 1'b0;
                     win_x     <= '0;
                     win_y     <= '0;
                     win_size  <= COORD_W'(WIN_MIN);
                     win_scale <= '0;
                  end else begin
                     win_x <= win_x + COORD_W'(STEP);
                  end
               end
            end
            SEL_CHK: begin
               if (!windows_out) begin
                  if (exhausted) begin
                     windows_out <= 1'b1;
                     win_x       <= prev_x;
                     win_y       <= prev_y;
                     win_size    <= prev_size;
                     win_scale   <= prev_scale;
                  end else begin
                     win_x     <= x_wrap ? '0 : win_x;
                     win_y     <= y_wrap ? '0 : y_next[COORD_W-1:0];
                     win_scale <= scale_next[SCALE_W-1:0];
                     win_size  <= size_of(scale_next);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_face_window_selector.sv
// Self-checking bench for face_window_selector on a 32x32 frame with two scales;
// expected windows come from a scan list built directly from the scan rules.
module tb_face_window_selector;

   localparam int TB_W     = 32;
   localparam int TB_H     = 32;
   localparam int TB_MIN   = 24;
   localparam int TB_INC   = 8;
   localparam int TB_NS    = 2;
   localparam int TB_STEP  = 4;

   typedef struct {
      int x;
      int y;
      int size;
      int scale;
   } win_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       brk;
   logic       done;
   logic       windows_out;
   logic [7:0] win_x, win_y, win_size;
   logic [1:0] win_scale;

   face_window_selector #(
      .IMG_W(TB_W), .IMG_H(TB_H), .WIN_MIN(TB_MIN), .WIN_INC(TB_INC),
      .NUM_SCALES(TB_NS), .STEP(TB_STEP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .select_window_start(start),
      .break_scan(brk),
      .done(done),
      .windows_out(windows_out),
      .win_x(win_x),
      .win_y(win_y),
      .win_size(win_size),
      .win_scale(win_scale)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   win_t wins[$];
   int   idx;
   bit   pend;
   int   pend_cycle;
   win_t exp_win;
   int   exp_wo;
   bit   armed;

   int   tests = 0;
   int   fails = 0;
   bit   pinned = 0;
   bit   exp_done;

   task automatic checkOutput(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one cycle of start/break and advances the request model accordingly.
   task automatic applyStimulus(input bit s, input bit b);
      @(posedge clk);
      #1;
      start = s;
      brk   = b;
      if (b) begin
         if (pend && pend_cycle > cyc) pend = 1'b0;
         idx = 0;
      end else if (s && !(pend && cyc <= pend_cycle)) begin
         pend       = 1'b1;
         pend_cycle = cyc + 3;
         if (idx < wins.size()) begin
            exp_win = wins[idx];
            exp_wo  = 0;
            idx++;
         end else begin
            exp_win = wins[wins.size()-1];
            exp_wo  = 1;
         end
      end
   endtask

   task automatic issueRequest();
      applyStimulus(1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0);
   endtask

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         #1;
         checkOutput("reset_done", int'(done), 0);
         checkOutput("reset_windows_out", int'(windows_out), 0);
         checkOutput("reset_x", int'(win_x), 0);
         checkOutput("reset_y", int'(win_y), 0);
         checkOutput("reset_size", int'(win_size), TB_MIN);
         checkOutput("reset_scale", int'(win_scale), 0);
      end else if (armed) begin
         if (!pinned) begin
            pinned = 1'b1;
            checkOutput("model_count", wins.size(), 10);
            checkOutput("model_w8_x", wins[8].x, 8);
            checkOutput("model_w8_y", wins[8].y, 8);
            checkOutput("model_w9_size", wins[9].size, 32);
            checkOutput("model_w9_scale", wins[9].scale, 1);
            checkOutput("model_w9_x", wins[9].x, 0);
         end
         exp_done = pend && (cyc == pend_cycle);
         checkOutput("done", int'(done), int'(exp_done));
         if (exp_done) begin
            checkOutput("win_x", int'(win_x), exp_win.x);
            checkOutput("win_y", int'(win_y), exp_win.y);
            checkOutput("win_size", int'(win_size), exp_win.size);
            checkOutput("win_scale", int'(win_scale), exp_win.scale);
            checkOutput("windows_out", int'(windows_out), exp_wo);
         end
      end
   end

   initial begin
      start = 1'b0;
      brk   = 1'b0;
      rst_n = 1'b1;
      armed = 1'b0;
      pend  = 1'b0;
      pend_cycle = 0;
      idx   = 0;
      exp_wo = 0;
      exp_win = '{x: 0, y: 0, size: TB_MIN, scale: 0};

      for (int k = 0; k < TB_NS; k++) begin
         int sz;
         sz = TB_MIN + k * TB_INC;
         for (int y = 0; y + sz <= TB_H; y += TB_STEP)
            for (int x = 0; x + sz <= TB_W; x += TB_STEP)
               wins.push_back('{x: x, y: y, size: sz, scale: k});
      end

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      armed = 1'b1;

      // Full scan of ten windows, then two requests past exhaustion.
      repeat (10) issueRequest();
      repeat (2) issueRequest();

      // Break after exhaustion restarts the scan.
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      issueRequest();

      // Break one cycle after start aborts; simultaneous start+break is dropped.
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0);
      issueRequest();
      applyStimulus(1'b1, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0);

      // Starts while busy are ignored.
      repeat (4) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0);

      // Asynchronous reset in the middle of CHK.
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      pend  = 1'b0;
      idx   = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      issueRequest();
      repeat (3) applyStimulus(1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
